// File: rtl/tc_tile_buffer.sv
// Tile store for the sparse tensor core operand path: DEPTH slots of TILE_M x TILE_K tiles
// with per-slot occupancy, valid/ready writes and a registered read with optional transpose/consume.
module tc_tile_buffer #(
    parameter int unsigned DW_DATA = 16,
    parameter int unsigned TILE_M  = 4,
    parameter int unsigned TILE_K  = 4,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned DW_IDX  = $clog2(DEPTH),
    parameter int unsigned DW_TILE = TILE_M * TILE_K * DW_DATA,
    parameter int unsigned DW_CNT  = DW_IDX + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [DW_IDX-1:0]  wr_ptr,
    input  logic [DW_TILE-1:0] wr_data,
    input  logic               rd_req,
    input  logic [DW_IDX-1:0]  rd_ptr,
    input  logic               rd_trans,
    input  logic               rd_consume,
    output logic               rd_valid,
    output logic               rd_err,
    output logic [DW_TILE-1:0] rd_tile,
    output logic [DW_CNT-1:0]  count,
    output logic               full,
    output logic               empty
);

    logic [DW_TILE-1:0] mem [DEPTH];
    logic [DEPTH-1:0]   valid;
    logic [DEPTH-1:0]   valid_nxt;
    logic               wr_fire;
    logic               rd_hit;
    logic               cons_fire;
    logic [DW_TILE-1:0] rd_raw;
    logic [DW_TILE-1:0] rd_xpose;

    assign wr_ready  = ~valid[wr_ptr] & ~clear;
    assign wr_fire   = wr_valid & wr_ready;
    assign rd_hit    = valid[rd_ptr];
    assign cons_fire = rd_req & rd_consume & rd_hit & ~clear;
    assign rd_raw    = mem[rd_ptr];

    assign full  = (count == DW_CNT'(DEPTH));
    assign empty = (count == '0);

    // Element (m,k) moves to position (k,m) of a TILE_K x TILE_M tile
    always_comb begin
        rd_xpose = '0;
        for (int unsigned m = 0; m < TILE_M; m++) begin
            for (int unsigned k = 0; k < TILE_K; k++) begin
                rd_xpose[(k*TILE_M+m)*DW_DATA +: DW_DATA] = rd_raw[(m*TILE_K+k)*DW_DATA +: DW_DATA];
            end
        end
    end

    // A write and a consume can never hit the same slot: the write needs it empty, the consume full
    always_comb begin
        valid_nxt = valid;
        if (cons_fire) valid_nxt[rd_ptr] = 1'b0;
        if (wr_fire)   valid_nxt[wr_ptr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid    <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            rd_tile  <= '0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_err  <= ~rd_hit;
                rd_tile <= !rd_hit ? '0 : (rd_trans ? rd_xpose : rd_raw);
            end
            if (clear) begin
                valid <= '0;
                count <= '0;
            end else begin
                valid <= valid_nxt;
                case ({wr_fire, cons_fire})
                    2'b10:   count <= count + DW_CNT'(1);
                    2'b01:   count <= count - DW_CNT'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tc_tile_buffer.sv
// Directed bench for tc_tile_buffer: a behavioural slot model feeds a read scoreboard queue,
// and every cycle checks wr_ready, read responses and occupancy flags.
module tb_tc_tile_buffer;

    localparam int unsigned DW_DATA = 16;
    localparam int unsigned TILE_M  = 4;
    localparam int unsigned TILE_K  = 4;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned DW_IDX  = 4;
    localparam int unsigned DW_TILE = 256;
    localparam int unsigned DW_CNT  = 5;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               clear;
    logic               wr_valid;
    logic               wr_ready;
    logic [DW_IDX-1:0]  wr_ptr;
    logic [DW_TILE-1:0] wr_data;
    logic               rd_req;
    logic [DW_IDX-1:0]  rd_ptr;
    logic               rd_trans;
    logic               rd_consume;
    logic               rd_valid;
    logic               rd_err;
    logic [DW_TILE-1:0] rd_tile;
    logic [DW_CNT-1:0]  count;
    logic               full;
    logic               empty;

    tc_tile_buffer #(
        .DW_DATA(DW_DATA),
        .TILE_M (TILE_M),
        .TILE_K (TILE_K),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_ptr    (wr_ptr),
        .wr_data   (wr_data),
        .rd_req    (rd_req),
        .rd_ptr    (rd_ptr),
        .rd_trans  (rd_trans),
        .rd_consume(rd_consume),
        .rd_valid  (rd_valid),
        .rd_err    (rd_err),
        .rd_tile   (rd_tile),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic               err;
        logic [DW_TILE-1:0] tile;
    } rd_exp_t;

    rd_exp_t            exp_q[$];
    logic [DW_TILE-1:0] m_mem [DEPTH];
    logic [DEPTH-1:0]   m_valid;
    int unsigned        m_count;
    logic [DW_TILE-1:0] last_tile;
    int                 n_cmp = 0;
    int                 n_mis = 0;

    function automatic logic [DW_TILE-1:0] mk_tile(input int unsigned i);
        logic [DW_TILE-1:0] t;
        for (int unsigned j = 0; j < TILE_M*TILE_K; j++) t[j*DW_DATA +: DW_DATA] = 16'(i*16 + j);
        return t;
    endfunction

    function automatic logic [DW_TILE-1:0] xpose(input logic [DW_TILE-1:0] t);
        logic [DW_TILE-1:0] o;
        for (int unsigned r = 0; r < TILE_M; r++)
            for (int unsigned c = 0; c < TILE_K; c++)
                o[(c*TILE_M+r)*DW_DATA +: DW_DATA] = t[(r*TILE_K+c)*DW_DATA +: DW_DATA];
        return o;
    endfunction

    task automatic chk(input string tag, input logic [DW_TILE-1:0] obs, input logic [DW_TILE-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic idle();
        clear = 1'b0; wr_valid = 1'b0; wr_ptr = '0; wr_data = '0;
        rd_req = 1'b0; rd_ptr = '0; rd_trans = 1'b0; rd_consume = 1'b0;
    endtask

    // One clock with the currently driven inputs; model updated from pre-edge state
    task automatic cycle();
        rd_exp_t e;
        logic    exp_rdy, wfire, cfire, pend;
        #1;
        exp_rdy = ~m_valid[wr_ptr] & ~clear;
        chk("wr_ready", DW_TILE'(wr_ready), DW_TILE'(exp_rdy));
        wfire = wr_valid & exp_rdy;
        cfire = rd_req & rd_consume & m_valid[rd_ptr] & ~clear;
        pend  = rd_req;
        if (rd_req) begin
            e.err  = ~m_valid[rd_ptr];
            e.tile = !m_valid[rd_ptr] ? '0 : (rd_trans ? xpose(m_mem[rd_ptr]) : m_mem[rd_ptr]);
            exp_q.push_back(e);
        end
        if (clear) begin
            m_valid = '0;
            m_count = 0;
        end else begin
            if (wfire) begin
                m_mem[wr_ptr]   = wr_data;
                m_valid[wr_ptr] = 1'b1;
                m_count++;
            end
            if (cfire) begin
                m_valid[rd_ptr] = 1'b0;
                m_count--;
            end
        end
        @(posedge clk);
        #1;
        chk("rd_valid", DW_TILE'(rd_valid), DW_TILE'(pend));
        if (pend) begin
            e = exp_q.pop_front();
            chk("rd_err", DW_TILE'(rd_err), DW_TILE'(e.err));
            chk("rd_tile", rd_tile, e.tile);
            last_tile = e.tile;
        end else begin
            chk("rd_tile_hold", rd_tile, last_tile);
        end
        chk("count", DW_TILE'(count), DW_TILE'(m_count));
        chk("full", DW_TILE'(full), DW_TILE'(m_count == DEPTH));
        chk("empty", DW_TILE'(empty), DW_TILE'(m_count == 0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        reset_n   = 1'b0;
        m_valid   = '0;
        m_count   = 0;
        last_tile = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", DW_TILE'(count), '0);
        chk("reset_empty", DW_TILE'(empty), DW_TILE'(1));
        chk("reset_full", DW_TILE'(full), '0);
        chk("reset_rd_valid", DW_TILE'(rd_valid), '0);
        chk("reset_rd_err", DW_TILE'(rd_err), '0);
        chk("reset_rd_tile", rd_tile, '0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;

        // T1: fill every slot, then a write to an occupied slot must be refused
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1; wr_ptr = DW_IDX'(i); wr_data = mk_tile(i);
            cycle();
        end
        wr_valid = 1'b1; wr_ptr = 4'd3; wr_data = '1;
        cycle();
        chk("t1_full", DW_TILE'(full), DW_TILE'(1));
        idle();

        // T2: plain read, then rd_tile holds through an idle cycle
        rd_req = 1'b1; rd_ptr = 4'd5;
        cycle();
        chk("t2_elem0", DW_TILE'(rd_tile[0 +: 16]), DW_TILE'(16'h0050));
        chk("t2_elem15", DW_TILE'(rd_tile[15*16 +: 16]), DW_TILE'(16'h005F));
        idle();
        cycle();

        // T3: transposed read
        rd_req = 1'b1; rd_ptr = 4'd1; rd_trans = 1'b1;
        cycle();
        chk("t3_out_k0m1", DW_TILE'(rd_tile[1*16 +: 16]), DW_TILE'(16'h0014));
        chk("t3_out_k1m0", DW_TILE'(rd_tile[4*16 +: 16]), DW_TILE'(16'h0011));
        idle();

        // Refused write to slot 3 left the original tile intact
        rd_req = 1'b1; rd_ptr = 4'd3;
        cycle();

        // T4: consume slot 2, then it reads as empty
        rd_req = 1'b1; rd_ptr = 4'd2; rd_consume = 1'b1;
        cycle();
        rd_consume = 1'b0;
        cycle();
        idle();

        // T5: write slot 2 while consuming slot 7
        wr_valid = 1'b1; wr_ptr = 4'd2; wr_data = mk_tile(100);
        rd_req = 1'b1; rd_ptr = 4'd7; rd_consume = 1'b1;
        cycle();
        idle();
        rd_req = 1'b1; rd_ptr = 4'd2;
        cycle();
        rd_ptr = 4'd7;
        cycle();
        idle();

        // Write and read the same empty slot: read sees the pre-edge empty state
        wr_valid = 1'b1; wr_ptr = 4'd7; wr_data = mk_tile(77);
        rd_req = 1'b1; rd_ptr = 4'd7;
        cycle();
        idle();
        rd_req = 1'b1; rd_ptr = 4'd7;
        cycle();
        idle();

        // Write slot X while consuming slot X: only the consume happens
        wr_valid = 1'b1; wr_ptr = 4'd4; wr_data = mk_tile(44);
        rd_req = 1'b1; rd_ptr = 4'd4; rd_consume = 1'b1;
        cycle();
        idle();
        rd_req = 1'b1; rd_ptr = 4'd4;
        cycle();
        idle();

        // T6: clear beats write and consume; the read in that cycle still sees old contents
        clear = 1'b1;
        wr_valid = 1'b1; wr_ptr = 4'd0; wr_data = mk_tile(9);
        rd_req = 1'b1; rd_ptr = 4'd5; rd_consume = 1'b1;
        cycle();
        idle();
        wr_valid = 1'b1; wr_ptr = 4'd0; wr_data = mk_tile(9);
        cycle();
        idle();
        rd_req = 1'b1; rd_ptr = 4'd0;
        cycle();
        idle();

        // Async reset while a read is outstanding
        rd_req = 1'b1; rd_ptr = 4'd0;
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_async_count", DW_TILE'(count), '0);
        @(posedge clk);
        #1;
        chk("rst_rd_valid", DW_TILE'(rd_valid), '0);
        chk("rst_count", DW_TILE'(count), '0);
        chk("rst_empty", DW_TILE'(empty), DW_TILE'(1));
        chk("rst_rd_tile", rd_tile, '0);
        idle();
        m_valid   = '0;
        m_count   = 0;
        last_tile = '0;
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        rd_req = 1'b1; rd_ptr = 4'd0;
        cycle();
        idle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
